// File: rtl/mem_arb_ram_if.sv
// Request/grant and read-return bundle for the arbitrated RAM.
// Handshake: ch_req[i] is held until ch_gnt[i] is seen high; transfer happens in that cycle.
interface mem_arb_ram_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]       ch_req;
  logic [NUM_CH-1:0]       ch_we;
  logic [NUM_CH*16-1:0]    ch_addr;
  logic [NUM_CH*WIDTH-1:0] ch_wdata;
  logic [NUM_CH-1:0]       ch_gnt;
  logic [NUM_CH-1:0]       rd_valid;
  logic [WIDTH-1:0]        rd_data;
  logic                    rd_err;
  logic                    wr_err;

  modport master (
    output ch_req, ch_we, ch_addr, ch_wdata,
    input  ch_gnt, rd_valid, rd_data, rd_err, wr_err
  );

  modport slave (
    input  ch_req, ch_we, ch_addr, ch_wdata,
    output ch_gnt, rd_valid, rd_data, rd_err, wr_err
  );
endinterface

// File: rtl/mem_arb_ram.sv
// Single-port synchronous RAM shared by NUM_CH requestors through a round-robin
// arbiter, with a tagged RD_LAT-stage read return path and range checking.
module mem_arb_ram #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4096,
  parameter int NUM_CH = 2,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arb_ram_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [16:0] DEPTH_C = 17'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [CW-1:0]     r_ptr;
  logic              r_wr_err;

  logic [NUM_CH-1:0] r_pv    [RD_LAT];
  logic              r_perr  [RD_LAT];
  logic [WIDTH-1:0]  r_pdata [RD_LAT];

  logic [NUM_CH-1:0] w_gnt;
  logic [CW-1:0]     w_sel;
  logic              w_any;
  logic              w_we;
  logic [15:0]       w_addr;
  logic [WIDTH-1:0]  w_wdata;
  logic              w_in_range;
  logic [AW-1:0]     w_idx;
  logic              w_do_wr;
  logic              w_do_rd;

  // Scan from r_ptr upward with wrap; first requester wins. Reset masks every grant.
  always_comb begin
    logic [CW:0] v_cand;
    v_cand = '0;
    w_gnt  = '0;
    w_sel  = '0;
    w_any  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      v_cand = {1'b0, r_ptr} + (CW+1)'(k);
      if (v_cand >= (CW+1)'(NUM_CH)) v_cand = v_cand - (CW+1)'(NUM_CH);
      if (!w_any && bus.ch_req[v_cand[CW-1:0]]) begin
        w_any = 1'b1;
        w_sel = v_cand[CW-1:0];
      end
    end
    w_any = w_any & rst_n;
    if (w_any) w_gnt[w_sel] = 1'b1;
  end

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_sel == CW'(i)) begin
        w_we    = bus.ch_we[i];
        w_addr  = bus.ch_addr[16*i +: 16];
        w_wdata = bus.ch_wdata[WIDTH*i +: WIDTH];
      end
    end
  end

  assign w_in_range = ({1'b0, w_addr} < DEPTH_C);
  assign w_idx      = w_addr[AW-1:0];
  assign w_do_wr    = w_any & w_we & w_in_range;
  assign w_do_rd    = w_any & ~w_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_any) begin
      if (w_sel == CW'(NUM_CH-1)) r_ptr <= '0;
      else                        r_ptr <= w_sel + 1'b1;
    end
  end

  // Storage has no reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[w_idx] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_wr_err <= 1'b0;
    else        r_wr_err <= w_any & w_we & ~w_in_range;
  end

  // Data advances only alongside a valid tag, so the last stage holds between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LAT; s++) begin
        r_pv[s]    <= '0;
        r_perr[s]  <= 1'b0;
        r_pdata[s] <= '0;
      end
    end else begin
      r_pv[0]   <= w_do_rd ? w_gnt : '0;
      r_perr[0] <= w_do_rd & ~w_in_range;
      if (w_do_rd) r_pdata[0] <= w_in_range ? r_mem[w_idx] : '0;
      for (int s = 1; s < RD_LAT; s++) begin
        r_pv[s]   <= r_pv[s-1];
        r_perr[s] <= r_perr[s-1];
        if (|r_pv[s-1]) r_pdata[s] <= r_pdata[s-1];
      end
    end
  end

  assign bus.ch_gnt   = w_gnt;
  assign bus.rd_valid = r_pv[RD_LAT-1] & {NUM_CH{rst_n}};
  assign bus.rd_data  = rst_n ? r_pdata[RD_LAT-1] : '0;
  assign bus.rd_err   = r_perr[RD_LAT-1] & rst_n;
  assign bus.wr_err   = r_wr_err & rst_n;
endmodule

// File: tb/tb_mem_arb_ram.sv
// Directed bench for mem_arb_ram: three instances at RD_LAT 1, 3 and 2 sharing clock and reset.
module tb_mem_arb_ram;
  localparam int W = 16;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arb_ram_if #(.WIDTH(W), .NUM_CH(N)) if_a ();
  mem_arb_ram_if #(.WIDTH(W), .NUM_CH(N)) if_b ();
  mem_arb_ram_if #(.WIDTH(W), .NUM_CH(N)) if_c ();

  mem_arb_ram #(.WIDTH(W), .DEPTH(4096), .NUM_CH(N), .RD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  mem_arb_ram #(.WIDTH(W), .DEPTH(4096), .NUM_CH(N), .RD_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  mem_arb_ram #(.WIDTH(W), .DEPTH(4096), .NUM_CH(N), .RD_LAT(2)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [1:0] req, input logic [1:0] we,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [W-1:0] d0, input logic [W-1:0] d1);
    if_a.ch_req = req; if_a.ch_we = we;
    if_a.ch_addr = {a1, a0}; if_a.ch_wdata = {d1, d0};
  endtask

  task automatic drive_b(input logic [1:0] req, input logic [1:0] we,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [W-1:0] d0, input logic [W-1:0] d1);
    if_b.ch_req = req; if_b.ch_we = we;
    if_b.ch_addr = {a1, a0}; if_b.ch_wdata = {d1, d0};
  endtask

  task automatic drive_c(input logic [1:0] req, input logic [1:0] we,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [W-1:0] d0, input logic [W-1:0] d1);
    if_c.ch_req = req; if_c.ch_we = we;
    if_c.ch_addr = {a1, a0}; if_c.ch_wdata = {d1, d0};
  endtask

  task automatic idle_all();
    drive_a(2'b00, 2'b00, 16'h0, 16'h0, '0, '0);
    drive_b(2'b00, 2'b00, 16'h0, 16'h0, '0, '0);
    drive_c(2'b00, 2'b00, 16'h0, 16'h0, '0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_a(2'b11, 2'b01, 16'h0000, 16'h0001, 16'hAAAA, 16'h5555);
    drive_b(2'b11, 2'b00, 16'h0000, 16'h0001, '0, '0);
    drive_c(2'b11, 2'b10, 16'h0000, 16'h0001, '0, 16'h1234);
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      checks++; if (if_a.ch_gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt_a cyc=%0d got=%b exp=00", c, if_a.ch_gnt); end
      checks++; if (if_a.rd_valid !== 2'b00) begin failures++; $display("FAIL reset_rd_valid cyc=%0d got=%b exp=00", c, if_a.rd_valid); end
      checks++; if (if_a.rd_data !== 16'h0000) begin failures++; $display("FAIL reset_rd_data cyc=%0d got=%h exp=0000", c, if_a.rd_data); end
      checks++; if (if_a.rd_err !== 1'b0) begin failures++; $display("FAIL reset_rd_err cyc=%0d got=%b exp=0", c, if_a.rd_err); end
      checks++; if (if_a.wr_err !== 1'b0) begin failures++; $display("FAIL reset_wr_err cyc=%0d got=%b exp=0", c, if_a.wr_err); end
      checks++; if (if_b.ch_gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt_b cyc=%0d got=%b exp=00", c, if_b.ch_gnt); end
      checks++; if (if_c.ch_gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt_c cyc=%0d got=%b exp=00", c, if_c.ch_gnt); end
    end
    tick();
    rst_n = 1'b1;
    idle_all();
  endtask

  task automatic test_write_read();
    tick();
    drive_a(2'b01, 2'b01, 16'h0010, 16'h0, 16'hBEEF, '0);
    @(negedge clk);
    checks++; if (if_a.ch_gnt !== 2'b01) begin failures++; $display("FAIL wr_gnt got=%b exp=01", if_a.ch_gnt); end
    tick();
    drive_a(2'b01, 2'b00, 16'h0010, 16'h0, '0, '0);
    @(negedge clk);
    checks++; if (if_a.ch_gnt !== 2'b01) begin failures++; $display("FAIL rd_gnt got=%b exp=01", if_a.ch_gnt); end
    checks++; if (if_a.rd_valid !== 2'b00) begin failures++; $display("FAIL wr_no_valid got=%b exp=00", if_a.rd_valid); end
    checks++; if (if_a.wr_err !== 1'b0) begin failures++; $display("FAIL wr_in_range_err got=%b exp=0", if_a.wr_err); end
    tick();
    idle_all();
    @(negedge clk);
    checks++; if (if_a.rd_valid !== 2'b01) begin failures++; $display("FAIL rd_valid got=%b exp=01", if_a.rd_valid); end
    checks++; if (if_a.rd_data !== 16'hBEEF) begin failures++; $display("FAIL rd_data got=%h exp=beef", if_a.rd_data); end
    checks++; if (if_a.rd_err !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", if_a.rd_err); end
    tick();
    @(negedge clk);
    checks++; if (if_a.rd_valid !== 2'b00) begin failures++; $display("FAIL rd_valid_pulse got=%b exp=00", if_a.rd_valid); end
    checks++; if (if_a.rd_data !== 16'hBEEF) begin failures++; $display("FAIL rd_data_hold got=%h exp=beef", if_a.rd_data); end
  endtask

  // Pointer sits at 1 after the two ch0 grants above, so ch1 wins the first tie.
  task automatic test_round_robin();
    logic [1:0] exp_g;
    logic [1:0] prev_g;
    logic [W-1:0] exp_d;
    tick();
    drive_a(2'b11, 2'b11, 16'h0020, 16'h0021, 16'h1111, 16'h2222);
    @(negedge clk);
    checks++; if (if_a.ch_gnt !== 2'b10) begin failures++; $display("FAIL rr_wr1_gnt got=%b exp=10", if_a.ch_gnt); end
    tick();
    drive_a(2'b01, 2'b01, 16'h0020, 16'h0021, 16'h1111, 16'h2222);
    @(negedge clk);
    checks++; if (if_a.ch_gnt !== 2'b01) begin failures++; $display("FAIL rr_wr2_gnt got=%b exp=01", if_a.ch_gnt); end
    prev_g = 2'b00;
    exp_q.delete();
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k < 6) begin
        drive_a(2'b11, 2'b00, 16'h0020, 16'h0021, '0, '0);
        exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
      end else begin
        idle_all();
        exp_g = 2'b00;
      end
      @(negedge clk);
      checks++; if (if_a.ch_gnt !== exp_g) begin failures++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, if_a.ch_gnt, exp_g); end
      checks++; if (if_a.rd_valid !== prev_g) begin failures++; $display("FAIL rr_valid k=%0d got=%b exp=%b", k, if_a.rd_valid, prev_g); end
      if (prev_g != 2'b00 && exp_q.size() > 0) begin
        exp_d = exp_q.pop_front();
        checks++; if (if_a.rd_data !== exp_d) begin failures++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, if_a.rd_data, exp_d); end
      end
      if (exp_g == 2'b10) exp_q.push_back(16'h2222);
      if (exp_g == 2'b01) exp_q.push_back(16'h1111);
      prev_g = exp_g;
    end
  endtask

  task automatic test_latency_order();
    logic [1:0] exp_v;
    logic [W-1:0] exp_d;
    for (int i = 1; i <= 3; i++) begin
      tick();
      drive_b(2'b10, 2'b10, 16'h0, 16'(i), '0, 16'hA000 + 16'(i));
    end
    for (int t = 0; t < 8; t++) begin
      tick();
      if (t < 3) drive_b(2'b10, 2'b00, 16'h0, 16'(t + 1), '0, '0);
      else       drive_b(2'b00, 2'b00, 16'h0, 16'h0, '0, '0);
      exp_v = (t >= 3 && t <= 5) ? 2'b10 : 2'b00;
      exp_d = (t < 3) ? 16'h0000 : (t <= 5) ? 16'hA000 + 16'(t - 2) : 16'hA003;
      @(negedge clk);
      if (t < 3) begin
        checks++; if (if_b.ch_gnt !== 2'b10) begin failures++; $display("FAIL lat_gnt t=%0d got=%b exp=10", t, if_b.ch_gnt); end
      end
      checks++; if (if_b.rd_valid !== exp_v) begin failures++; $display("FAIL lat_valid t=%0d got=%b exp=%b", t, if_b.rd_valid, exp_v); end
      checks++; if (if_b.rd_data !== exp_d) begin failures++; $display("FAIL lat_data t=%0d got=%h exp=%h", t, if_b.rd_data, exp_d); end
    end
  endtask

  task automatic test_range();
    tick();
    drive_a(2'b01, 2'b01, 16'h0000, 16'h0, 16'h5A5A, '0);
    @(negedge clk);
    checks++; if (if_a.ch_gnt !== 2'b01) begin failures++; $display("FAIL rng_gnt got=%b exp=01", if_a.ch_gnt); end
    tick();
    drive_a(2'b01, 2'b01, 16'h1000, 16'h0, 16'h1234, '0);
    @(negedge clk);
    checks++; if (if_a.wr_err !== 1'b0) begin failures++; $display("FAIL rng_wr_err_early got=%b exp=0", if_a.wr_err); end
    tick();
    drive_a(2'b01, 2'b01, 16'h0FFF, 16'h0, 16'h7777, '0);
    @(negedge clk);
    checks++; if (if_a.wr_err !== 1'b1) begin failures++; $display("FAIL rng_wr_err_pulse got=%b exp=1", if_a.wr_err); end
    tick();
    drive_a(2'b01, 2'b00, 16'h0000, 16'h0, '0, '0);
    @(negedge clk);
    checks++; if (if_a.wr_err !== 1'b0) begin failures++; $display("FAIL rng_wr_err_end got=%b exp=0", if_a.wr_err); end
    tick();
    drive_a(2'b01, 2'b00, 16'h1000, 16'h0, '0, '0);
    @(negedge clk);
    checks++; if (if_a.rd_valid !== 2'b01) begin failures++; $display("FAIL rng_valid0 got=%b exp=01", if_a.rd_valid); end
    checks++; if (if_a.rd_data !== 16'h5A5A) begin failures++; $display("FAIL rng_addr0_kept got=%h exp=5a5a", if_a.rd_data); end
    checks++; if (if_a.rd_err !== 1'b0) begin failures++; $display("FAIL rng_err0 got=%b exp=0", if_a.rd_err); end
    tick();
    drive_a(2'b01, 2'b00, 16'h0FFF, 16'h0, '0, '0);
    @(negedge clk);
    checks++; if (if_a.rd_valid !== 2'b01) begin failures++; $display("FAIL rng_valid_oor got=%b exp=01", if_a.rd_valid); end
    checks++; if (if_a.rd_data !== 16'h0000) begin failures++; $display("FAIL rng_data_oor got=%h exp=0000", if_a.rd_data); end
    checks++; if (if_a.rd_err !== 1'b1) begin failures++; $display("FAIL rng_err_oor got=%b exp=1", if_a.rd_err); end
    tick();
    idle_all();
    @(negedge clk);
    checks++; if (if_a.rd_data !== 16'h7777) begin failures++; $display("FAIL rng_data_top got=%h exp=7777", if_a.rd_data); end
    checks++; if (if_a.rd_err !== 1'b0) begin failures++; $display("FAIL rng_err_top got=%b exp=0", if_a.rd_err); end
    tick();
    @(negedge clk);
    checks++; if (if_a.rd_valid !== 2'b00) begin failures++; $display("FAIL rng_valid_idle got=%b exp=00", if_a.rd_valid); end
    checks++; if (if_a.rd_data !== 16'h7777) begin failures++; $display("FAIL rng_data_hold got=%h exp=7777", if_a.rd_data); end
  endtask

  task automatic test_midop_reset();
    tick();
    drive_c(2'b01, 2'b01, 16'h0040, 16'h0, 16'hC0DE, '0);
    tick();
    drive_c(2'b01, 2'b00, 16'h0040, 16'h0, '0, '0);
    tick();
    drive_c(2'b00, 2'b00, 16'h0, 16'h0, '0, '0);
    @(negedge clk);
    checks++; if (if_c.rd_valid !== 2'b00) begin failures++; $display("FAIL mid_valid_g1 got=%b exp=00", if_c.rd_valid); end
    tick();
    @(negedge clk);
    checks++; if (if_c.rd_valid !== 2'b01) begin failures++; $display("FAIL mid_valid_g2 got=%b exp=01", if_c.rd_valid); end
    checks++; if (if_c.rd_data !== 16'hC0DE) begin failures++; $display("FAIL mid_data_g2 got=%h exp=c0de", if_c.rd_data); end
    tick();
    drive_c(2'b01, 2'b00, 16'h0040, 16'h0, '0, '0);
    @(negedge clk);
    checks++; if (if_c.ch_gnt !== 2'b01) begin failures++; $display("FAIL mid_gnt got=%b exp=01", if_c.ch_gnt); end
    tick();
    rst_n = 1'b0;
    drive_c(2'b00, 2'b00, 16'h0, 16'h0, '0, '0);
    @(negedge clk);
    checks++; if (if_c.rd_valid !== 2'b00) begin failures++; $display("FAIL mid_rst_valid got=%b exp=00", if_c.rd_valid); end
    checks++; if (if_c.rd_data !== 16'h0000) begin failures++; $display("FAIL mid_rst_data got=%h exp=0000", if_c.rd_data); end
    tick();
    drive_c(2'b11, 2'b11, 16'h0041, 16'h0042, 16'hDEAD, 16'hDEAD);
    @(negedge clk);
    checks++; if (if_c.ch_gnt !== 2'b00) begin failures++; $display("FAIL mid_rst_gnt got=%b exp=00", if_c.ch_gnt); end
    checks++; if (if_c.rd_valid !== 2'b00) begin failures++; $display("FAIL mid_rst_valid2 got=%b exp=00", if_c.rd_valid); end
    tick();
    rst_n = 1'b1;
    drive_c(2'b11, 2'b00, 16'h0040, 16'h0040, '0, '0);
    @(negedge clk);
    checks++; if (if_c.ch_gnt !== 2'b01) begin failures++; $display("FAIL mid_tie_gnt got=%b exp=01", if_c.ch_gnt); end
    checks++; if (if_c.rd_valid !== 2'b00) begin failures++; $display("FAIL mid_post_valid got=%b exp=00", if_c.rd_valid); end
    checks++; if (if_c.rd_data !== 16'h0000) begin failures++; $display("FAIL mid_post_data got=%h exp=0000", if_c.rd_data); end
    tick();
    drive_c(2'b10, 2'b00, 16'h0040, 16'h0040, '0, '0);
    @(negedge clk);
    checks++; if (if_c.ch_gnt !== 2'b10) begin failures++; $display("FAIL mid_next_gnt got=%b exp=10", if_c.ch_gnt); end
    tick();
    drive_c(2'b00, 2'b00, 16'h0, 16'h0, '0, '0);
    @(negedge clk);
    checks++; if (if_c.rd_valid !== 2'b01) begin failures++; $display("FAIL mid_ret0_valid got=%b exp=01", if_c.rd_valid); end
    checks++; if (if_c.rd_data !== 16'hC0DE) begin failures++; $display("FAIL mid_ret0_data got=%h exp=c0de", if_c.rd_data); end
    tick();
    @(negedge clk);
    checks++; if (if_c.rd_valid !== 2'b10) begin failures++; $display("FAIL mid_ret1_valid got=%b exp=10", if_c.rd_valid); end
    checks++; if (if_c.rd_data !== 16'hC0DE) begin failures++; $display("FAIL mid_ret1_data got=%h exp=c0de", if_c.rd_data); end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_write_read();
    test_round_robin();
    test_latency_order();
    test_range();
    test_midop_reset();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
